// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter (one bit per clock) with start/busy/done handshake, sticky overflow and leading-zero blanking
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  input  logic                  i_blank_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow,
  output logic [DIGITS-1:0]     o_blank
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state_q;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] work_q, work_d, adj;
  logic                ovf_q, ovf_d;
  logic [CW-1:0]       cnt_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                out_ovf_q;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d +: 4] = (work_q[4*d +: 4] >= 4'd5) ? work_q[4*d +: 4] + 4'd3 : work_q[4*d +: 4];
  end
  always_comb begin
    work_d = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
    bin_d  = bin_q << 1;
    ovf_d  = ovf_q | adj[4*DIGITS-1];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      work_q    <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          bin_q   <= i_bin;
          work_q  <= '0;
          ovf_q   <= 1'b0;
          cnt_q   <= CW'(WIDTH);
          state_q <= SHIFT;
        end
        SHIFT: begin
          bin_q  <= bin_d;
          work_q <= work_d;
          ovf_q  <= ovf_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q     <= work_d;
            out_ovf_q <= ovf_d;
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_bcd      = bcd_q;
  assign o_overflow = out_ovf_q;
  for (genvar d = 0; d < DIGITS; d++) begin : g_blank
    if (d == 0) begin : g_units
      assign o_blank[d] = 1'b0;
    end else begin : g_high
      assign o_blank[d] = i_blank_en && (o_bcd[4*DIGITS-1:4*d] == '0);
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and randomized checks of bin_to_bcd_seq in four WIDTH/DIGITS configurations against an arithmetic decimal model
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst, en;
  logic st3, st2, st4, st1;
  logic [7:0] b3, b2;
  logic [3:0] b4;
  logic [0:0] b1;
  logic bz3, dn3, ov3, bz2, dn2, ov2, bz4, dn4, ov4, bz1, dn1, ov1;
  logic [11:0] q3;
  logic [7:0] q2, q4;
  logic [3:0] q1;
  logic [2:0] bl3;
  logic [1:0] bl2, bl4;
  logic [0:0] bl1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u3 (.i_clk(clk), .i_reset(rst), .i_start(st3), .i_bin(b3), .i_blank_en(en),
    .o_busy(bz3), .o_done(dn3), .o_bcd(q3), .o_overflow(ov3), .o_blank(bl3));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u2 (.i_clk(clk), .i_reset(rst), .i_start(st2), .i_bin(b2), .i_blank_en(en),
    .o_busy(bz2), .o_done(dn2), .o_bcd(q2), .o_overflow(ov2), .o_blank(bl2));
  bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u4 (.i_clk(clk), .i_reset(rst), .i_start(st4), .i_bin(b4), .i_blank_en(en),
    .o_busy(bz4), .o_done(dn4), .o_bcd(q4), .o_overflow(ov4), .o_blank(bl4));
  bin_to_bcd_seq #(.WIDTH(1), .DIGITS(1)) u1 (.i_clk(clk), .i_reset(rst), .i_start(st1), .i_bin(b1), .i_blank_en(en),
    .o_busy(bz1), .o_done(dn1), .o_bcd(q1), .o_overflow(ov1), .o_blank(bl1));
  function automatic int width_of(input int w);
    return (w == 3 || w == 2) ? 8 : (w == 4) ? 4 : 1;
  endfunction
  function automatic int digits_of(input int w);
    return (w == 3) ? 3 : (w == 1) ? 1 : 2;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int w, input logic s, input int b);
    case (w)
      3: begin st3 = s; b3 = b[7:0]; end
      2: begin st2 = s; b2 = b[7:0]; end
      4: begin st4 = s; b4 = b[3:0]; end
      default: begin st1 = s; b1 = b[0:0]; end
    endcase
  endtask
  task automatic samp(input int w, output logic busy, output logic done, output logic [15:0] bcd,
                      output logic ovf, output logic [2:0] blank);
    case (w)
      3: begin busy = bz3; done = dn3; bcd = 16'(q3); ovf = ov3; blank = bl3; end
      2: begin busy = bz2; done = dn2; bcd = 16'(q2); ovf = ov2; blank = 3'(bl2); end
      4: begin busy = bz4; done = dn4; bcd = 16'(q4); ovf = ov4; blank = 3'(bl4); end
      default: begin busy = bz1; done = dn1; bcd = 16'(q1); ovf = ov1; blank = 3'(bl1); end
    endcase
  endtask
  task automatic model(input int b, input int d, input logic e, output logic [15:0] bcd,
                       output logic ovf, output logic [2:0] blank);
    int m, v;
    logic z;
    m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    ovf = (b >= m);
    v = b % m;
    bcd = '0;
    for (int i = 0; i < d; i++) begin
      bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    blank = '0;
    z = 1'b1;
    for (int i = d - 1; i >= 1; i--) begin
      if (bcd[4*i +: 4] != 4'd0) z = 1'b0;
      blank[i] = e & z;
    end
  endtask
  task automatic run(input int w, input int b, input logic e, input string tag);
    logic busy, done, ovf, eovf;
    logic [15:0] bcd, ebcd;
    logic [2:0] blank, eblank;
    int n;
    en = e;
    @(negedge clk);
    drive(w, 1'b1, b);
    @(negedge clk);
    drive(w, 1'b0, b);
    samp(w, busy, done, bcd, ovf, blank);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      samp(w, busy, done, bcd, ovf, blank);
    end
    check({tag, "_lat"}, 32'(n), 32'(width_of(w)));
    model(b, digits_of(w), e, ebcd, eovf, eblank);
    check({tag, "_bcd"}, 32'(bcd), 32'(ebcd));
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    check({tag, "_blank"}, 32'(blank), 32'(eblank));
    @(negedge clk);
    samp(w, busy, done, bcd, ovf, blank);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(bcd), 32'(ebcd));
  endtask
  initial begin
    logic busy, done, ovf;
    logic [15:0] bcd;
    logic [2:0] blank;
    int nd, da, w, b;
    rst = 1'b1; en = 1'b0;
    drive(3, 1'b0, 0); drive(2, 1'b0, 0); drive(4, 1'b0, 0); drive(1, 1'b0, 0);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      samp(i, busy, done, bcd, ovf, blank);
      check("rst_state", {bcd, 13'd0, busy, done, ovf}, 32'd0);
    end
    rst = 1'b0;
    run(3, 255, 1'b1, "w8d3_255");
    samp(3, busy, done, bcd, ovf, blank);
    check("w8d3_255_lit", 32'(bcd), 32'h255);
    run(3, 7, 1'b1, "w8d3_7_en");
    samp(3, busy, done, bcd, ovf, blank);
    check("w8d3_7_blank_lit", 32'(blank), 32'b110);
    en = 1'b0;
    #1;
    samp(3, busy, done, bcd, ovf, blank);
    check("w8d3_7_blank_off", 32'(blank), 32'b000);
    run(3, 0, 1'b1, "w8d3_0");
    @(negedge clk);
    drive(3, 1'b1, 100);
    @(negedge clk);
    drive(3, 1'b0, 42);
    nd = 0; da = -1;
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) @(negedge clk);
      samp(3, busy, done, bcd, ovf, blank);
      if (done) begin nd++; da = n; end
      if (n == 9) check("ign_idle", 32'(busy), 32'd0);
      drive(3, (n == 2 || n == 7 || n == 8), 42);
    end
    check("ign_ndone", 32'(nd), 32'd1);
    check("ign_doneat", 32'(da), 32'd8);
    check("ign_bcd", 32'(bcd), 32'h100);
    run(3, 42, 1'b1, "w8d3_42");
    @(negedge clk);
    drive(3, 1'b1, 200);
    @(negedge clk);
    drive(3, 1'b0, 200);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    samp(3, busy, done, bcd, ovf, blank);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_bcd", 32'(bcd), 32'd0);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      samp(3, busy, done, bcd, ovf, blank);
      if (done) nd++;
    end
    check("rstmid_nodone", 32'(nd), 32'd0);
    run(3, 9, 1'b0, "w8d3_9");
    run(2, 200, 1'b0, "w8d2_200");
    samp(2, busy, done, bcd, ovf, blank);
    check("w8d2_200_lit", {15'd0, ovf, bcd}, 32'h10000);
    run(2, 99, 1'b1, "w8d2_99");
    for (int i = 0; i < 16; i++) run(4, i, 1'(i % 2), "w4d2_sweep");
    run(1, 0, 1'b1, "w1d1_0");
    run(1, 1, 1'b1, "w1d1_1");
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(1, 4);
      b = $urandom_range(0, (1 << width_of(w)) - 1);
      run(w, b, 1'($urandom_range(0, 1)), "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
